control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Sequencing FSM for the 16-bit processor datapath: owns PC and IR, fetches from instruction
//  memory, decodes, drives register-file, ALU, data-memory and write-back mux controls.
//  Sits inside Processor between instruction ROM, data RAM, register file and ALU; PC_Out,
//  IR_Out and StateO also feed the board hex displays.
// PARAMETERS
//  PC_W    8   PC / instruction-address width (PC wraps modulo 2**PC_W)
//  DATA_W  16  instruction width
//  RF_AW   4   register-file address width
// PORTS
//  Clk        in   1       rising-edge clock (one clock for the whole block)
//  Reset      in   1       asynchronous, active-low reset (0 = reset)
//  IM_Q       in   16      instruction memory read data, valid the cycle after IM_Rd
//  IM_Addr    out  PC_W    instruction address (= PC_Out)
//  IM_Rd      out  1       instruction read strobe
//  PC_Out     out  PC_W    program counter
//  IR_Out     out  16      instruction register
//  StateO     out  4       current state encoding
//  D_Addr     out  8       data memory address
//  D_Rd       out  1       data memory read strobe (sync RAM, 1-cycle latency)
//  D_Wr       out  1       data memory write enable
//  RF_s       out  1       write-back mux select: 1 = data memory, 0 = ALU
//  RF_W_addr  out  RF_AW   register write address
//  RF_W_en    out  1       register write enable
//  RF_Ra_addr out  RF_AW   read port A address
//  RF_Rb_addr out  RF_AW   read port B address
//  ALU_s0     out  3       ALU op: 0 pass A, 1 A+B, 2 A-B
// BEHAVIOUR
//  Registers: state, PC, IR only. All other outputs are combinational from state and IR (Moore).
//  Reset (Reset=0, async): state=INIT(0), PC=0, IR=0. D_Wr, RF_W_en, IM_Rd and D_Rd fall to 0
//  immediately, even mid-instruction. Unlisted outputs are 0 in every state.
//  ISA: op=IR[15:12]. NOOP 0. LOAD 1: RF[IR[11:8]] <= D[IR[7:0]]. STORE 2: D[IR[7:0]] <= RF[IR[11:8]].
//  ADD 3 / SUB 4: RF[IR[3:0]] <= RF[IR[11:8]] +/- RF[IR[7:4]]. HALT 5. Opcodes 6-15 execute as NOOP.
//  States:
//   0 INIT   -> FETCH.
//   1 FETCH  IM_Rd=1, IM_Addr=PC -> DECODE.
//   2 DECODE IR<=IM_Q, PC<=PC+1 (255 wraps to 0). Next state comes from IM_Q[15:12]:
//            1->LOAD_A, 2->STORE, 3->ADD, 4->SUB, 5->HALT, else NOOP.
//   3 NOOP   -> FETCH.
//   4 LOAD_A D_Addr=IR[7:0], D_Rd=1 -> LOAD_B.
//   5 LOAD_B D_Addr=IR[7:0], RF_s=1, RF_W_addr=IR[11:8], RF_W_en=1 -> FETCH.
//   6 STORE  D_Addr=IR[7:0], RF_Ra_addr=IR[11:8], ALU_s0=0, D_Wr=1 -> FETCH.
//   7 ADD    Ra=IR[11:8], Rb=IR[7:4], ALU_s0=1, RF_s=0, RF_W_addr=IR[3:0], RF_W_en=1 -> FETCH.
//   8 SUB    as ADD with ALU_s0=2 -> FETCH.
//   9 HALT   no strobes. Stays in HALT; only reset exits.
//   10-15    unreachable; if entered, go to INIT.
//  Cycle counts per instruction (FETCH to next FETCH): NOOP/STORE/ADD/SUB 3, LOAD 4.
//  PC changes only in INIT (clear) and DECODE (increment). IR changes only in INIT and DECODE.
// TESTING
//  1 Reset low mid-run -> StateO=0, PC=0, IR=0 at once. Release + 1 clk -> StateO=1, IM_Rd=1, IM_Addr=0.
//  2 ROM[0]=16'h3125 -> DECODE: IR=3125, PC=1. Then ADD: Ra=1, Rb=2, W_addr=5, W_en=1, ALU_s0=1.
//    Then FETCH.
//  3 ROM[1]=16'h1A07 -> LOAD_A: D_Addr=07, D_Rd=1. LOAD_B: RF_s=1, W_addr=A, W_en=1.
//    Total 4 clks FETCH->FETCH.
//  4 ROM[2]=16'h2B40 -> STORE: D_Wr=1 for exactly 1 clk, D_Addr=40, Ra=B. ROM[3]=16'hF000 -> NOOP path.
//  5 ROM[4]=16'h5000 -> HALT. 20 further clks: StateO=9, PC=5, no strobes. Reset exits to INIT.
//  6 PC=255 at DECODE, ROM[255]=0 -> PC=0. Next fetch IM_Addr=0. Reset asserted during STORE ->
//    D_Wr drops before next edge.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: sequencing FSM for the 16-bit processor datapath.
// Owns PC and IR, fetches from instruction memory and decodes the instruction.
// All datapath controls are Moore outputs decoded from the state and IR registers.
module control_unit #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] IM_Q,
    output logic [PC_W-1:0]   IM_Addr,
    output logic              IM_Rd,
    output logic [PC_W-1:0]   PC_Out,
    output logic [DATA_W-1:0] IR_Out,
    output logic [3:0]        StateO,
    output logic [7:0]        D_Addr,
    output logic              D_Rd,
    output logic              D_Wr,
    output logic              RF_s,
    output logic [RF_AW-1:0]  RF_W_addr,
    output logic              RF_W_en,
    output logic [RF_AW-1:0]  RF_Ra_addr,
    output logic [RF_AW-1:0]  RF_Rb_addr,
    output logic [2:0]        ALU_s0
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_ir;

    logic                w_im_rd;
    logic [7:0]          w_d_addr;
    logic                w_d_rd;
    logic                w_d_wr;
    logic                w_rf_s;
    logic [RF_AW-1:0]    w_rf_w_addr;
    logic                w_rf_w_en;
    logic [RF_AW-1:0]    w_rf_ra_addr;
    logic [RF_AW-1:0]    w_rf_rb_addr;
    logic [2:0]          w_alu_s0;

    // State register; async reset forces INIT so every strobe drops at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC and IR: cleared in INIT, loaded/incremented in DECODE, held elsewhere.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc <= {PC_W{1'b0}};
            r_ir <= {DATA_W{1'b0}};
        end else if (r_state == ST_INIT) begin
            r_pc <= {PC_W{1'b0}};
            r_ir <= {DATA_W{1'b0}};
        end else if (r_state == ST_DECODE) begin
            r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            r_ir <= IM_Q;
        end else begin
            r_pc <= r_pc;
            r_ir <= r_ir;
        end
    end

    // Next-state logic and Moore control decode; unused controls default to 0.
    always_comb begin
        w_next_state = ST_INIT;
        w_im_rd      = 1'b0;
        w_d_addr     = 8'd0;
        w_d_rd       = 1'b0;
        w_d_wr       = 1'b0;
        w_rf_s       = 1'b0;
        w_rf_w_addr  = {RF_AW{1'b0}};
        w_rf_w_en    = 1'b0;
        w_rf_ra_addr = {RF_AW{1'b0}};
        w_rf_rb_addr = {RF_AW{1'b0}};
        w_alu_s0     = 3'd0;
        case (r_state)
            ST_INIT: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_im_rd      = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Decode straight from memory data; IR is only written at this edge.
                case (IM_Q[15:12])
                    4'd1:    w_next_state = ST_LOAD_A;
                    4'd2:    w_next_state = ST_STORE;
                    4'd3:    w_next_state = ST_ADD;
                    4'd4:    w_next_state = ST_SUB;
                    4'd5:    w_next_state = ST_HALT;
                    default: w_next_state = ST_NOOP;
                endcase
            end
            ST_NOOP: begin
                w_next_state = ST_FETCH;
            end
            ST_LOAD_A: begin
                w_d_addr     = r_ir[7:0];
                w_d_rd       = 1'b1;
                w_next_state = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                w_d_addr     = r_ir[7:0];
                w_rf_s       = 1'b1;
                w_rf_w_addr  = r_ir[11:8];
                w_rf_w_en    = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_STORE: begin
                w_d_addr     = r_ir[7:0];
                w_rf_ra_addr = r_ir[11:8];
                w_alu_s0     = 3'd0;
                w_d_wr       = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                w_rf_ra_addr = r_ir[11:8];
                w_rf_rb_addr = r_ir[7:4];
                w_alu_s0     = (r_state == ST_ADD) ? 3'd1 : 3'd2;
                w_rf_s       = 1'b0;
                w_rf_w_addr  = r_ir[3:0];
                w_rf_w_en    = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    assign IM_Addr    = r_pc;
    assign IM_Rd      = w_im_rd;
    assign PC_Out     = r_pc;
    assign IR_Out     = r_ir;
    assign StateO     = r_state;
    assign D_Addr     = w_d_addr;
    assign D_Rd       = w_d_rd;
    assign D_Wr       = w_d_wr;
    assign RF_s       = w_rf_s;
    assign RF_W_addr  = w_rf_w_addr;
    assign RF_W_en    = w_rf_w_en;
    assign RF_Ra_addr = w_rf_ra_addr;
    assign RF_Rb_addr = w_rf_rb_addr;
    assign ALU_s0     = w_alu_s0;

endmodule
